// File: rtl/ifid_hazard_stage.sv
// ifid_hazard_stage
//   IF/ID pipeline register with built-in hazard control. It holds the
//   fetched instruction and PC+4 for decode. It detects load-use and
//   HI/LO read-after-write hazards against the instruction now in ID/EX.
//   It drives the PC enable and the ID/EX bubble request, and it keeps a
//   saturating count of stalled cycles for performance debug.
//
// Ports
//   Clk              clock, all state updates on posedge
//   Rst              synchronous reset, active-low
//   InstrIn[31:0]    instruction from instruction memory
//   PCAdderIn[31:0]  PC+4 from the fetch adder
//   IDEX_MemRead     ID/EX instruction is a load
//   IDEX_RT[4:0]     ID/EX load destination register
//   IDEX_HiLoEnable  ID/EX HI/LO write enables (nonzero = writes HI/LO)
//   BranchTaken      branch resolved taken this cycle
//   JumpTaken        jump redirect this cycle
//   InstrOut[31:0]   registered instruction to decode
//   PCAdderOut[31:0] registered PC+4 to decode
//   PCWrite          PC register enable (0 = hold PC)
//   IDEXFlush        bubble into ID/EX
//   Stalled          high whenever PCWrite is low
//   StallCycles      saturating stalled-cycle count
module ifid_hazard_stage #(
    parameter int          HILO_LAT  = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] InstrIn,
    input  logic [31:0] PCAdderIn,
    input  logic        IDEX_MemRead,
    input  logic [4:0]  IDEX_RT,
    input  logic [3:0]  IDEX_HiLoEnable,
    input  logic        BranchTaken,
    input  logic        JumpTaken,
    output logic [31:0] InstrOut,
    output logic [31:0] PCAdderOut,
    output logic        PCWrite,
    output logic        IDEXFlush,
    output logic        Stalled,
    output logic [15:0] StallCycles
);

    typedef enum logic {RUN, HILO_WAIT} state_t;

    // The first stall cycle is spent in RUN, so the wait counter covers
    // the remaining HILO_LAT-1 cycles and counts down to zero inclusive.
    localparam logic [3:0] HILO_INIT = (HILO_LAT >= 2) ? 4'(HILO_LAT - 2) : 4'd0;

    state_t     state;
    logic [3:0] cnt;

    logic [4:0] rs, rt;
    logic [5:0] op, fn;
    logic       redirect, load_use, hilo_use;

    assign rs = InstrOut[25:21];
    assign rt = InstrOut[20:16];
    assign op = InstrOut[31:26];
    assign fn = InstrOut[5:0];

    assign redirect = BranchTaken | JumpTaken;
    assign load_use = IDEX_MemRead & (IDEX_RT != 5'd0) & ((IDEX_RT == rs) | (IDEX_RT == rt));
    // mfhi (fn 0x10) / mflo (fn 0x12) behind an op that writes HI/LO
    assign hilo_use = (IDEX_HiLoEnable != 4'd0) & (op == 6'd0) & ((fn == 6'h10) | (fn == 6'h12));

    always_comb begin
        PCWrite   = 1'b1;
        IDEXFlush = 1'b0;
        if (state == HILO_WAIT) begin
            // Only a redirect releases the PC during the HI/LO wait.
            PCWrite   = redirect;
            IDEXFlush = 1'b1;
        end else if (redirect) begin
            PCWrite   = 1'b1;
            IDEXFlush = 1'b1;
        end else if (load_use | hilo_use) begin
            PCWrite   = 1'b0;
            IDEXFlush = 1'b1;
        end
    end

    assign Stalled = ~PCWrite;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            InstrOut    <= NOP_INSTR;
            PCAdderOut  <= 32'd0;
            state       <= RUN;
            cnt         <= 4'd0;
            StallCycles <= 16'd0;
        end else begin
            if (Stalled && StallCycles != 16'hFFFF)
                StallCycles <= StallCycles + 16'd1;

            case (state)
                RUN: begin
                    if (redirect) begin
                        InstrOut   <= NOP_INSTR;
                        PCAdderOut <= 32'd0;
                    end else if (load_use) begin
                        // Hold; the bubble now entering ID/EX clears the hazard.
                    end else if (hilo_use) begin
                        if (HILO_LAT != 1) begin
                            cnt   <= HILO_INIT;
                            state <= HILO_WAIT;
                        end
                    end else begin
                        InstrOut   <= InstrIn;
                        PCAdderOut <= PCAdderIn;
                    end
                end
                HILO_WAIT: begin
                    if (redirect) begin
                        InstrOut   <= NOP_INSTR;
                        PCAdderOut <= 32'd0;
                        cnt        <= 4'd0;
                        state      <= RUN;
                    end else if (cnt == 4'd0) begin
                        state <= RUN;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_ifid_hazard_stage.sv
// Testbench for ifid_hazard_stage: directed vector table, a reset-mid-wait
// sequence, randomized traffic against a behavioural model, and counter
// saturation.
module tb_ifid_hazard_stage;

    localparam int HILO_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_in, pc_in;
    logic        mem_read;
    logic [4:0]  idex_rt;
    logic [3:0]  hilo_en;
    logic        br, jp;
    logic [31:0] instr_out, pc_out;
    logic        pc_write, idex_flush, stalled;
    logic [15:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ifid_hazard_stage #(.HILO_LAT(HILO_LAT), .NOP_INSTR(32'h0)) dut (
        .Clk(clk), .Rst(rst), .InstrIn(instr_in), .PCAdderIn(pc_in),
        .IDEX_MemRead(mem_read), .IDEX_RT(idex_rt), .IDEX_HiLoEnable(hilo_en),
        .BranchTaken(br), .JumpTaken(jp),
        .InstrOut(instr_out), .PCAdderOut(pc_out), .PCWrite(pc_write),
        .IDEXFlush(idex_flush), .Stalled(stalled), .StallCycles(stall_cycles)
    );

    typedef struct packed {
        logic        rst;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        mr;
        logic [4:0]  rt;
        logic [3:0]  hl;
        logic        br;
        logic        jp;
        logic        cc;       // check combinational outputs this row
        logic        e_pcw;
        logic        e_fl;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic [15:0] e_sc;
    } vec_t;

    vec_t vec [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [31:0] i, input logic [31:0] p,
                         input logic m, input logic [4:0] t, input logic [3:0] h,
                         input logic b, input logic j);
        rst = r; instr_in = i; pc_in = p; mem_read = m; idex_rt = t;
        hilo_en = h; br = b; jp = j;
    endtask

    // Move to just after the next active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: remaining HI/LO stall cycles as a plain integer.
    logic [31:0] m_instr, m_pc;
    int          m_wait, m_sc;
    logic        m_pcw, m_fl;

    task automatic model_comb();
        logic redir, lu, hu;
        redir = br | jp;
        lu = mem_read && idex_rt != 0 && (idex_rt == m_instr[25:21] || idex_rt == m_instr[20:16]);
        hu = hilo_en != 0 && m_instr[31:26] == 0 && (m_instr[5:0] == 6'h10 || m_instr[5:0] == 6'h12);
        if (m_wait > 0)      begin m_pcw = redir; m_fl = 1'b1; end
        else if (redir)      begin m_pcw = 1'b1;  m_fl = 1'b1; end
        else if (lu || hu)   begin m_pcw = 1'b0;  m_fl = 1'b1; end
        else                 begin m_pcw = 1'b1;  m_fl = 1'b0; end
    endtask

    task automatic model_step();
        logic redir, lu, hu;
        redir = br | jp;
        lu = mem_read && idex_rt != 0 && (idex_rt == m_instr[25:21] || idex_rt == m_instr[20:16]);
        hu = hilo_en != 0 && m_instr[31:26] == 0 && (m_instr[5:0] == 6'h10 || m_instr[5:0] == 6'h12);
        if (!rst) begin
            m_instr = 0; m_pc = 0; m_wait = 0; m_sc = 0;
        end else begin
            if (!m_pcw && m_sc < 65535) m_sc++;
            if (m_wait > 0) begin
                if (redir) begin m_instr = 0; m_pc = 0; m_wait = 0; end
                else m_wait--;
            end else if (redir) begin
                m_instr = 0; m_pc = 0;
            end else if (lu) begin
            end else if (hu) begin
                m_wait = HILO_LAT - 1;
            end else begin
                m_instr = instr_in; m_pc = pc_in;
            end
        end
    endtask

    initial begin
        //        rst instr          pc  mr rt  hl    br jp  cc pcw fl  e_instr        e_pc e_sc
        vec[0]  = '{1'b0, 32'h0,        32'd0,  1'b0, 5'd0,  4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'd0,  16'd0};
        vec[1]  = '{1'b1, 32'h012A4020, 32'd4,  1'b0, 5'd0,  4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h012A4020, 32'd4,  16'd0};
        vec[2]  = '{1'b1, 32'hDEADBEEF, 32'd8,  1'b1, 5'd9,  4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h012A4020, 32'd4,  16'd1};
        vec[3]  = '{1'b1, 32'h00004010, 32'd8,  1'b1, 5'd0,  4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00004010, 32'd8,  16'd1};
        vec[4]  = '{1'b1, 32'h11111111, 32'd12, 1'b0, 5'd0,  4'h1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00004010, 32'd8,  16'd2};
        vec[5]  = '{1'b1, 32'h11111111, 32'd12, 1'b0, 5'd0,  4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00004010, 32'd8,  16'd3};
        vec[6]  = '{1'b1, 32'h22222222, 32'd16, 1'b0, 5'd0,  4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h22222222, 32'd16, 16'd3};
        vec[7]  = '{1'b1, 32'h55555555, 32'd20, 1'b1, 5'd17, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0,        32'd0,  16'd3};
        vec[8]  = '{1'b1, 32'h00004012, 32'd20, 1'b0, 5'd0,  4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00004012, 32'd20, 16'd3};
        vec[9]  = '{1'b1, 32'h66666666, 32'd24, 1'b0, 5'd0,  4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00004012, 32'd20, 16'd4};
        vec[10] = '{1'b1, 32'h77777777, 32'd28, 1'b0, 5'd0,  4'h2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0,        32'd0,  16'd4};
        vec[11] = '{1'b1, 32'h00004010, 32'd32, 1'b0, 5'd0,  4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00004010, 32'd32, 16'd4};
        vec[12] = '{1'b1, 32'h88888888, 32'd36, 1'b0, 5'd0,  4'h8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h00004010, 32'd32, 16'd5};
        vec[13] = '{1'b0, 32'h99999999, 32'd40, 1'b0, 5'd0,  4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        32'd0,  16'd0};
        vec[14] = '{1'b1, 32'h44444444, 32'd44, 1'b0, 5'd0,  4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h44444444, 32'd44, 16'd0};

        drive(1'b0, 0, 0, 1'b0, 5'd0, 4'h0, 1'b0, 1'b0);
        #1;

        // Directed table
        for (int i = 0; i < 15; i++) begin
            drive(vec[i].rst, vec[i].instr, vec[i].pc, vec[i].mr, vec[i].rt,
                  vec[i].hl, vec[i].br, vec[i].jp);
            #1;
            if (vec[i].cc) begin
                chk($sformatf("vec%0d pcwrite", i), {31'd0, pc_write}, {31'd0, vec[i].e_pcw});
                chk($sformatf("vec%0d flush", i), {31'd0, idex_flush}, {31'd0, vec[i].e_fl});
                chk($sformatf("vec%0d stalled", i), {31'd0, stalled}, {31'd0, ~vec[i].e_pcw});
            end
            tick();
            chk($sformatf("vec%0d instr", i), instr_out, vec[i].e_instr);
            chk($sformatf("vec%0d pc", i), pc_out, vec[i].e_pc);
            chk($sformatf("vec%0d stallcnt", i), {16'd0, stall_cycles}, {16'd0, vec[i].e_sc});
        end

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ri;
            logic [4:0]  rr;
            case ($urandom_range(0, 3))
                0: ri = 32'h00004010;
                1: ri = 32'h00004012 | ({$urandom} & 32'h03FF0000);
                default: ri = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: rr = m_instr[25:21];
                1: rr = m_instr[20:16];
                2: rr = 5'd0;
                default: rr = 5'($urandom);
            endcase
            drive((n == 0) ? 1'b0 : ($urandom_range(0, 31) != 0), ri, $urandom,
                  $urandom_range(0, 3) == 0, rr,
                  ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
            #1;
            if (n == 0) begin
                m_instr = 0; m_pc = 0; m_wait = 0; m_sc = 0;
            end else begin
                model_comb();
                chk("rnd pcwrite", {31'd0, pc_write}, {31'd0, m_pcw});
                chk("rnd flush", {31'd0, idex_flush}, {31'd0, m_fl});
                chk("rnd stalled", {31'd0, stalled}, {31'd0, ~m_pcw});
                model_step();
            end
            tick();
            chk("rnd instr", instr_out, m_instr);
            chk("rnd pc", pc_out, m_pc);
            chk("rnd stallcnt", {16'd0, stall_cycles}, 32'(m_sc));
        end

        // Saturation: a load-use held indefinitely stalls every cycle
        drive(1'b0, 0, 0, 1'b0, 5'd0, 4'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h012A4020, 32'd4, 1'b0, 5'd0, 4'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0, 32'd0, 1'b1, 5'd9, 4'h0, 1'b0, 1'b0);
        for (int c = 0; c < 65534; c++) @(posedge clk);
        #1;
        chk("sat below max", {16'd0, stall_cycles}, 32'h0000FFFE);
        tick();
        chk("sat at max", {16'd0, stall_cycles}, 32'h0000FFFF);
        for (int c = 0; c < 4465; c++) @(posedge clk);
        #1;
        chk("sat holds", {16'd0, stall_cycles}, 32'h0000FFFF);
        chk("sat instr held", instr_out, 32'h012A4020);
        rst = 1'b0;
        tick();
        chk("sat reset clears", {16'd0, stall_cycles}, 32'h0);
        chk("sat reset instr", instr_out, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
